// File: rtl/restoring_divider_module.sv
// Multi-cycle restoring divider producing quotient and remainder with a start/done handshake.
// Optional two's-complement mode is compiled in with `define DIVIDER_SIGNED_EN.
module restoring_divider_module #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] entry_1,
  input  logic [WIDTH-1:0] entry_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] output_1,
  output logic [WIDTH-1:0] output_2,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
`ifdef DIVIDER_SIGNED_EN
  localparam logic [1:0] StFix  = 2'd2;
`endif
  localparam logic [1:0] StDone = 2'd3;

  if (WIDTH < 2) begin : g_width_check
    $error("restoring_divider_module: WIDTH must be at least 2");
  end

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dbz_q, dbz_d;
`ifdef DIVIDER_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic             busy_int;
  logic             accept;
  logic [WIDTH-1:0] op_dvd;
  logic [WIDTH-1:0] op_dsr;

  // Restoring step datapath
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic [WIDTH:0]   rem_step;
  logic             step_ge;
  logic [WIDTH-1:0] quo_step;

`ifdef DIVIDER_SIGNED_EN
  assign busy_int = (state_q == StRun) || (state_q == StFix);
`else
  assign busy_int = (state_q == StRun);
`endif
  assign accept = start && !busy_int;

`ifdef DIVIDER_SIGNED_EN
  // Magnitudes; the most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign op_dvd = entry_1[WIDTH-1] ? (~entry_1 + 1'b1) : entry_1;
  assign op_dsr = entry_2[WIDTH-1] ? (~entry_2 + 1'b1) : entry_2;
`else
  assign op_dvd = entry_1;
  assign op_dsr = entry_2;
`endif

  always_comb begin
    rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dsr_q};
    step_ge   = (rem_shift >= {1'b0, dsr_q});
    rem_step  = step_ge ? rem_sub : rem_shift;
    quo_step  = {quo_q[WIDTH-2:0], step_ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif

    unique case (state_q)
      StRun: begin
        dvd_d = dvd_q << 1;
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
`ifdef DIVIDER_SIGNED_EN
          state_d = StFix;
`else
          state_d = StDone;
          q_out_d = quo_step;
          r_out_d = rem_step[WIDTH-1:0];
          dbz_d   = 1'b0;
`endif
        end
      end
`ifdef DIVIDER_SIGNED_EN
      StFix: begin
        state_d = StDone;
        q_out_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        r_out_d = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
        dbz_d   = 1'b0;
      end
`endif
      default: begin
        // Idle and Done both accept; Done otherwise falls back to Idle.
        if (state_q == StDone) begin
          state_d = StIdle;
        end
        if (accept) begin
          dvd_d = op_dvd;
          dsr_d = op_dsr;
          quo_d = '0;
          rem_d = '0;
          cnt_d = '0;
`ifdef DIVIDER_SIGNED_EN
          neg_quo_d = entry_1[WIDTH-1] ^ entry_2[WIDTH-1];
          neg_rem_d = entry_1[WIDTH-1];
`endif
          if (entry_2 == '0) begin
            state_d = StDone;
            q_out_d = '1;
            r_out_d = entry_1;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy        = busy_int;
  assign done        = (state_q == StDone);
  assign output_1    = q_out_q;
  assign output_2    = r_out_q;
  assign div_by_zero = dbz_q;

`ifndef SYNTHESIS
  done_excludes_busy_a : assert property (@(posedge clk) disable iff (reset) done |-> !busy);
`endif

endmodule
